// File: rtl/key_conditioner.sv
// Three-key conditioner: 2-flop synchronizer, shared 1 ms prescaler, per-key debounce FSM.
// Define KEY_RELEASE_PULSE_EN to add the key_release pulse output.
module key_conditioner #(
  parameter int unsigned CLK_HZ         = 50000000,
  parameter int unsigned DEBOUNCE_MS    = 20,
  parameter bit          KEY_ACTIVE_LOW = 1'b1
) (
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic [2:0] key_raw,
  output logic [2:0] key_level,
`ifdef KEY_RELEASE_PULSE_EN
  output logic [2:0] key_press,
  output logic [2:0] key_release
`else
  output logic [2:0] key_press
`endif
);

  localparam int unsigned TicksPerMs = CLK_HZ / 1000;
  localparam int unsigned PreW       = (TicksPerMs > 1) ? $clog2(TicksPerMs) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(TicksPerMs - 1);
  localparam logic [5:0] DebTarget    = 6'(DEBOUNCE_MS);
  localparam logic [2:0] RawIdle      = {3{KEY_ACTIVE_LOW}};

  typedef enum logic [1:0] {
    StReleased,
    StPressPend,
    StPressed,
    StReleasePend
  } state_e;

  function automatic logic [5:0] sat_inc(input logic [5:0] v);
    return (v == 6'h3f) ? v : v + 6'd1;
  endfunction

  // Synchronizer flops reset to the idle (released) raw level.
  logic [2:0] sync1_q, sync2_q, sample;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= RawIdle;
      sync2_q <= RawIdle;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
    end
  end

  assign sample = KEY_ACTIVE_LOW ? ~sync2_q : sync2_q;

  logic [PreW-1:0] pre_q;
  logic            tick;

  assign tick = (pre_q == PreLast);

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= tick ? '0 : pre_q + PreW'(1);
    end
  end

  state_e     state_q [3];
  state_e     state_d [3];
  logic [5:0] cnt_q   [3];
  logic [5:0] cnt_d   [3];
  logic [2:0] press_d, press_q;
`ifdef KEY_RELEASE_PULSE_EN
  logic [2:0] release_d, release_q;
`endif

  always_comb begin
    press_d = '0;
`ifdef KEY_RELEASE_PULSE_EN
    release_d = '0;
`endif
    for (int k = 0; k < 3; k++) begin
      state_d[k] = state_q[k];
      cnt_d[k]   = cnt_q[k];
      case (state_q[k])
        StReleased: begin
          if (sample[k]) begin
            state_d[k] = StPressPend;
            cnt_d[k]   = '0;
          end
        end
        StPressPend: begin
          if (!sample[k]) begin
            state_d[k] = StReleased;
            cnt_d[k]   = '0;
          end else if (tick) begin
            cnt_d[k] = sat_inc(cnt_q[k]);
            if (sat_inc(cnt_q[k]) >= DebTarget) begin
              state_d[k] = StPressed;
              press_d[k] = 1'b1;
            end
          end
        end
        StPressed: begin
          if (!sample[k]) begin
            state_d[k] = StReleasePend;
            cnt_d[k]   = '0;
          end
        end
        StReleasePend: begin
          if (sample[k]) begin
            state_d[k] = StPressed;
            cnt_d[k]   = '0;
          end else if (tick) begin
            cnt_d[k] = sat_inc(cnt_q[k]);
            if (sat_inc(cnt_q[k]) >= DebTarget) begin
              state_d[k] = StReleased;
`ifdef KEY_RELEASE_PULSE_EN
              release_d[k] = 1'b1;
`endif
            end
          end
        end
        default: begin
          state_d[k] = StReleased;
          cnt_d[k]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        state_q[k] <= StReleased;
        cnt_q[k]   <= '0;
      end
      press_q <= '0;
`ifdef KEY_RELEASE_PULSE_EN
      release_q <= '0;
`endif
    end else begin
      for (int k = 0; k < 3; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
      press_q <= press_d;
`ifdef KEY_RELEASE_PULSE_EN
      release_q <= release_d;
`endif
    end
  end

  // Level comes straight from the state register, so it moves on the same cycle as the pulses.
  always_comb begin
    key_level = '0;
    for (int k = 0; k < 3; k++) begin
      key_level[k] = (state_q[k] == StPressed) || (state_q[k] == StReleasePend);
    end
  end

  assign key_press = press_q;
`ifdef KEY_RELEASE_PULSE_EN
  assign key_release = release_q;
`endif

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner: a level-plus-timer reference model predicts pulses,
// a negedge monitor compares; directed scenarios check latency windows and corner cases.
module tb_key_conditioner;
  localparam int unsigned CLK_HZ     = 10000;
  localparam int unsigned DEB        = 4;
  localparam int unsigned CYC_PER_MS = CLK_HZ / 1000;

  logic       clk_50M = 1'b0;
  logic       rst_n   = 1'b0;
  logic [2:0] key_raw = 3'b111;
  logic [2:0] key_level, key_press, key_release;

  always #5 clk_50M = ~clk_50M;

  key_conditioner #(
    .CLK_HZ        (CLK_HZ),
    .DEBOUNCE_MS   (DEB),
    .KEY_ACTIVE_LOW(1'b1)
  ) dut (
    .clk_50M    (clk_50M),
    .rst_n      (rst_n),
    .key_raw    (key_raw),
    .key_level  (key_level),
`ifdef KEY_RELEASE_PULSE_EN
    .key_press  (key_press),
    .key_release(key_release)
`else
    .key_press  (key_press)
`endif
  );

`ifndef KEY_RELEASE_PULSE_EN
  assign key_release = 3'b000;
`endif

  typedef struct {
    int unsigned cyc;
    logic [2:0]  press;
    logic [2:0]  rel;
  } ev_t;

  ev_t         exp_q[$];
  int unsigned cyc = 0;
  int          n_total = 0;
  int          n_pass  = 0;

  task automatic chk(input string name, input int got, input int want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, got, want);
  endtask

  task automatic chk_rng(input string name, input int got, input int lo, input int hi);
    n_total++;
    if (got >= lo && got <= hi) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0d, expected %0d..%0d", name, cyc, got, lo, hi);
  endtask

  always @(posedge clk_50M) cyc <= cyc + 1;

  // Reference model: a key's level flips once its synchronized value has disagreed with the
  // level for DEB ms ticks, counting only ticks after the cycle the disagreement is noticed.
  logic [2:0] m_p1, m_p2, m_level;
  bit         m_pend  [3];
  int         m_ticks [3];
  int         m_phase;

  always @(posedge clk_50M or negedge rst_n) begin
    logic [2:0] s;
    bit         tk;
    ev_t        e;
    if (!rst_n) begin
      m_p1 = '0; m_p2 = '0; m_level = '0; m_phase = 0;
      for (int k = 0; k < 3; k++) begin
        m_pend[k] = 0; m_ticks[k] = 0;
      end
    end else begin
      s    = m_p2;
      m_p2 = m_p1;
      m_p1 = ~key_raw;
      tk      = (m_phase == CYC_PER_MS - 1);
      m_phase = (m_phase + 1) % CYC_PER_MS;
      e.cyc = cyc + 1; e.press = '0; e.rel = '0;
      for (int k = 0; k < 3; k++) begin
        if (s[k] == m_level[k]) m_pend[k] = 0;
        else if (!m_pend[k]) begin
          m_pend[k] = 1; m_ticks[k] = 0;
        end else if (tk) begin
          m_ticks[k]++;
          if (m_ticks[k] == DEB) begin
            m_level[k] = s[k];
            m_pend[k]  = 0;
            if (s[k]) e.press[k] = 1'b1;
            else      e.rel[k]   = 1'b1;
          end
        end
      end
`ifdef KEY_RELEASE_PULSE_EN
      if (e.press != 0 || e.rel != 0) exp_q.push_back(e);
`else
      if (e.press != 0) exp_q.push_back(e);
`endif
    end
  end

  int         press_cnt [3], last_press [3], rel_cnt [3], last_rel [3];
  int         fall_cnt  [3], last_fall  [3];
  logic [2:0] prev_level = '0;

  always @(negedge clk_50M) begin
    ev_t e;
    bit  have;
    have = 0;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      chk("missed event", 0, int'(e.cyc));
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      have = 1;
      if (!rst_n) begin  // reset aborts a pulse that was about to be shown
        e.press = '0; e.rel = '0;
      end
    end else begin
      e.press = '0; e.rel = '0;
    end
    chk("key_level", int'(key_level), int'(m_level));
    if (have || key_press != 0) chk("key_press", int'(key_press), int'(e.press));
`ifdef KEY_RELEASE_PULSE_EN
    if (have || key_release != 0) chk("key_release", int'(key_release), int'(e.rel));
`endif
    for (int k = 0; k < 3; k++) begin
      if (key_press[k])   begin press_cnt[k]++; last_press[k] = int'(cyc); end
      if (key_release[k]) begin rel_cnt[k]++;   last_rel[k]   = int'(cyc); end
      if (prev_level[k] && !key_level[k]) begin fall_cnt[k]++; last_fall[k] = int'(cyc); end
    end
    prev_level = key_level;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_50M);
    #2;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int  c0, p0, p2, f0, r0;
    bit  seen;
    int  durs [7];
    durs = '{5, 2, 6, 2, 6, 1, 3};
    for (int k = 0; k < 3; k++) begin
      press_cnt[k] = 0; last_press[k] = 0; rel_cnt[k] = 0;
      last_rel[k] = 0; fall_cnt[k] = 0; last_fall[k] = 0;
    end
    rst_n = 1'b0; key_raw = 3'b111;
    wait_cyc(3);
    chk("reset key_level", int'(key_level), 0);
    chk("reset key_press", int'(key_press), 0);
    rst_n = 1'b1;
    wait_cyc(20);

    // Single held key: latency window and a single pulse.
    c0 = int'(cyc); p0 = press_cnt[1];
    key_raw = 3'b101;
    wait_cyc(100);
    chk("hold press count", press_cnt[1] - p0, 1);
    chk_rng("hold press latency", last_press[1] - c0, 32, 44);
    chk("hold level", int'(key_level[1]), 1);
    c0 = int'(cyc); r0 = rel_cnt[1];
    key_raw = 3'b111;
    wait_cyc(100);
    chk("released level", int'(key_level[1]), 0);
`ifdef KEY_RELEASE_PULSE_EN
    chk("release count", rel_cnt[1] - r0, 1);
    chk_rng("release latency", last_rel[1] - c0, 32, 44);
    chk("level falls with release pulse", last_fall[1], last_rel[1]);
`endif

    // 25-cycle bouncy press on key 2 must be filtered out.
    p0 = press_cnt[2]; f0 = fall_cnt[2];
    for (int i = 0; i < 7; i++) begin
      key_raw = (i % 2 == 0) ? 3'b011 : 3'b111;
      wait_cyc(durs[i]);
    end
    key_raw = 3'b111;
    wait_cyc(60);
    chk("glitch press count", press_cnt[2] - p0, 0);
    chk("glitch level never rose", fall_cnt[2] - f0, 0);

    // Simultaneous presses on keys 0 and 2.
    p0 = press_cnt[0]; p2 = press_cnt[2];
    key_raw = 3'b010;
    wait_cyc(60);
    chk("simul press0 count", press_cnt[0] - p0, 1);
    chk("simul press2 count", press_cnt[2] - p2, 1);
    chk("simul same cycle", last_press[0], last_press[2]);
    key_raw = 3'b111;
    wait_cyc(60);

    // One-cycle bounce in the middle of a long press.
    p0 = press_cnt[0]; f0 = fall_cnt[0];
    key_raw = 3'b110; wait_cyc(60);
    key_raw = 3'b111; wait_cyc(1);
    key_raw = 3'b110; wait_cyc(59);
    chk("bounce press count", press_cnt[0] - p0, 1);
    chk("bounce no level drop", fall_cnt[0] - f0, 0);
    chk("bounce level", int'(key_level[0]), 1);
    key_raw = 3'b111;
    wait_cyc(60);

    // Reset in the middle of a debounce with the key held throughout.
    key_raw = 3'b101;
    wait_cyc(30);
    p0 = press_cnt[1];
    rst_n = 1'b0;
    #1;
    chk("mid reset level", int'(key_level), 0);
    chk("mid reset press", int'(key_press), 0);
    wait_cyc(3);
    rst_n = 1'b1;
    c0 = int'(cyc);
    wait_cyc(80);
    chk("post reset press count", press_cnt[1] - p0, 1);
    chk_rng("post reset latency", last_press[1] - c0, 40, 44);
    key_raw = 3'b111;
    wait_cyc(60);

    // Reset landing on the pulse cycle must swallow the pulse.
    key_raw = 3'b110;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      wait_cyc(1);
      if (key_press[0]) seen = 1;
    end
    chk("pulse seen before reset", int'(seen), 1);
    rst_n = 1'b0;
    #1;
    chk("pulse aborted by reset", int'(key_press), 0);
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(60);
    key_raw = 3'b111;
    wait_cyc(60);

    // Randomized stimulus, scoreboard-checked.
    for (int i = 0; i < 40; i++) begin
      key_raw = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 14) == 0) begin
        rst_n = 1'b0;
        wait_cyc(int'($urandom_range(1, 3)));
        rst_n = 1'b1;
      end
      wait_cyc(int'($urandom_range(1, 50)));
    end
    key_raw = 3'b111;
    wait_cyc(100);
    chk("scoreboard drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 Parameter CLK_HZ, default 50000000, input clock frequency in Hz; SHALL be a multiple of 1000.
REQ-002 Parameter DEBOUNCE_MS, default 20, required stable time in ms; legal range 1..63.
REQ-003 Parameter KEY_ACTIVE_LOW, default 1, 1 = raw key reads 0 when pressed.
REQ-004 clk_50M  input  1  single system clock; all state rising-edge triggered.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 key_raw  input  3  raw asynchronous buttons: [0]=clear, [1]=start, [2]=stop.
REQ-007 key_level  output  3  debounced level per key, 1 = pressed.
REQ-008 key_press  output  3  one-cycle pulse per key on debounced press.
REQ-009 key_release  output  3  one-cycle pulse per key on debounced release (present only under REQ-026).

Function
REQ-010 Each key_raw bit SHALL pass a 2-flop synchronizer, then be normalised so 1 = pressed per KEY_ACTIVE_LOW.
REQ-011 A shared prescaler SHALL count 0..CLK_HZ/1000-1 and assert a 1-cycle ms tick on the terminal count, then wrap to 0.
REQ-012 Each key SHALL run an independent 4-state FSM: RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND.
REQ-013 RELEASED: sample=1 -> PRESS_PEND with stable counter cleared; otherwise hold.
REQ-014 PRESS_PEND: sample=0 -> RELEASED, counter cleared; on tick with sample=1 counter increments; counter reaching DEBOUNCE_MS -> PRESSED.
REQ-015 RELEASE_PEND: mirror of PRESS_PEND; sample=1 -> PRESSED; counter reaching DEBOUNCE_MS -> RELEASED.
REQ-016 PRESSED: sample=0 -> RELEASE_PEND, counter cleared; otherwise hold.
REQ-017 Stable counter SHALL be 6 bits and SHALL never wrap; it clears on every pending-state entry.
REQ-018 key_level SHALL be 1 in PRESSED and RELEASE_PEND, 0 otherwise, registered.
REQ-019 key_press SHALL be high for exactly the one clk_50M cycle after the PRESS_PEND->PRESSED transition; never two consecutive cycles.
REQ-020 Press latency: from raw edge, 2 synchronizer cycles + between DEBOUNCE_MS-1 and DEBOUNCE_MS ms + 1 cycle.
REQ-021 Any glitch shorter than DEBOUNCE_MS-1 ms SHALL produce no level change and no pulse.
REQ-022 Simultaneous presses on several keys SHALL yield simultaneous pulses; no priority or suppression between keys.

Reset
REQ-023 While rst_n=0: all FSMs RELEASED, counters, prescaler and synchronizer flops at the released value, key_level=0, key_press=0, key_release=0.
REQ-024 Reset asserted mid-debounce or mid-pulse SHALL abort immediately, with no pulse emitted on deassertion.
REQ-025 After deassertion, a key held throughout reset SHALL produce exactly one key_press after the full debounce time.

Configuration
REQ-026 Macro KEY_RELEASE_PULSE_EN defined: key_release port exists and pulses for one cycle after each RELEASE_PEND->RELEASED transition.
REQ-027 Macro KEY_RELEASE_PULSE_EN undefined: key_release port and its logic are absent; all other behaviour is identical.

Verification (CLK_HZ=10000, i.e. 10 cycles/ms, DEBOUNCE_MS=4, KEY_ACTIVE_LOW=1)
REQ-028 Hold key_raw[1]=0 for 100 cycles -> key_level[1] rises and key_press[1] pulses exactly once, 32..44 cycles after the edge.
REQ-029 Pulse key_raw[2]=0 for 25 cycles, bouncing 3 times -> key_level[2] stays 0 and no key_press.
REQ-030 Press keys 0 and 2 on the same cycle -> key_press[0] and key_press[2] pulse on the same cycle.
REQ-031 Assert rst_n=0 for 3 cycles at the 30th cycle of a held key -> outputs 0 at once; one pulse follows ≥40 cycles after release of reset.
REQ-032 With KEY_RELEASE_PULSE_EN defined, press 100 cycles then release -> exactly one key_release pulse, 32..44 cycles after the release edge; key_level falls on the same cycle.
REQ-033 Hold key 120 cycles with a 1-cycle bounce at cycle 60 -> no extra key_press and key_level stays 1.
